// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and
// counter sizing helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } sub_state_e;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// Master drives operands and accepts results; slave is the subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, diff, bout);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, diff, bout);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock,
// with valid/ready on both operand and result sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, diff_q;
  logic [WIDTH-1:0] res_sr_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q;
  logic             d_bit, b_bit, last;

  full_subtractor u_fs (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (d_bit),
    .bout (b_bit)
  );

  // New bit enters at the MSB so the final shift leaves the result aligned.
  assign res_sr_d = (res_sr_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
  assign last     = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = SHIFT;
      SHIFT:   if (last)          state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          a_sr_q   <= bus.a;
          b_sr_q   <= bus.b;
          res_sr_q <= '0;
          cnt_q    <= '0;
          borrow_q <= 1'b0;
        end
        SHIFT: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= res_sr_d;
          borrow_q <= b_bit;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            diff_q <= res_sr_d;
            bout_q <= b_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Launch one operation on the 8-bit DUT; returns at the first negedge with out_valid.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string nm);
    int n;
    @(negedge clk);
    n = 0;
    while (!if8.in_ready && n < 50) begin @(negedge clk); n++; end
    chk({nm, "_in_ready"}, 64'(if8.in_ready), 64'd1);
    if8.a = a; if8.b = b; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_diff"}, 64'(if8.diff), 64'(ed));
    chk({nm, "_bout"}, 64'(if8.bout), 64'(eb));
    chk({nm, "_busy"}, 64'(if8.in_ready), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    logic [7:0] ra, rb;
    logic       a1, b1;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vecs[4] = '{8'h01, 8'hFF, 8'h02, 1'b1};
    vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[6] = '{8'hC3, 8'h3C, 8'h87, 1'b0};

    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;

    #1;
    chk("rst_in_ready",  64'(if8.in_ready),  64'd1);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_diff",      64'(if8.diff),      64'd0);
    chk("rst_bout",      64'(if8.bout),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].bout, $sformatf("vec%0d", i));

    // Back-pressure: HOLD persists and ignores new operands.
    @(negedge clk);
    if8.out_ready = 1'b0;
    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      if8.a = 8'h11; if8.b = 8'h22; if8.in_valid = 1'b1;
      @(negedge clk);
      chk("bp_hold_valid", 64'(if8.out_valid), 64'd1);
      chk("bp_hold_diff",  64'(if8.diff),      64'h1E);
      chk("bp_hold_bout",  64'(if8.bout),      64'd0);
      chk("bp_hold_rdy",   64'(if8.in_ready),  64'd0);
    end
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(if8.out_valid), 64'd0);
    chk("bp_release_rdy",   64'(if8.in_ready),  64'd1);
    chk("bp_idle_keep",     64'(if8.diff),      64'h1E);

    // Operand changes with in_valid high mid-SHIFT must not disturb the result.
    if8.a = 8'h5A; if8.b = 8'h3C; if8.in_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if8.a = 8'(i * 37 + 5); if8.b = 8'(i * 91 + 200);
      @(negedge clk);
    end
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 100) begin @(negedge clk); n++; end
    chk("ign_diff", 64'(if8.diff), 64'h1E);
    chk("ign_bout", 64'(if8.bout), 64'd0);

    // Prior result is 0xE1-? nonzero; reset mid-SHIFT clears it.
    op8(8'h00, 8'h1F, 8'hE1, 1'b1, "pre_rst");
    @(negedge clk);
    if8.a = 8'h5A; if8.b = 8'h3C; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(if8.out_valid), 64'd0);
    chk("mid_rst_diff",  64'(if8.diff),      64'd0);
    chk("mid_rst_bout",  64'(if8.bout),      64'd0);
    chk("mid_rst_rdy",   64'(if8.in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 64'(if8.out_valid), 64'd0);
    end
    op8(8'h10, 8'h01, 8'h0F, 1'b0, "post_rst");

    // Random 8-bit ops against the modular model.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      op8(ra, rb, ra - rb, 1'(ra < rb), "rnd8");
    end

    // WIDTH=1: one SHIFT cycle.
    @(negedge clk);
    chk("w1_in_ready", 64'(if1.in_ready), 64'd1);
    if1.a = 1'b0; if1.b = 1'b1; if1.in_valid = 1'b1;
    @(negedge clk);
    if1.in_valid = 1'b0;
    chk("w1_shift_not_valid", 64'(if1.out_valid), 64'd0);
    @(negedge clk);
    chk("w1_valid", 64'(if1.out_valid), 64'd1);
    chk("w1_diff",  64'(if1.diff),      64'd1);
    chk("w1_bout",  64'(if1.bout),      64'd1);

    // WIDTH=1 back-to-back random ops, in_valid held high.
    if1.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      n = 0;
      while (!if1.in_ready && n < 20) begin @(negedge clk); n++; end
      if (!if1.in_ready) begin
        n_chk++; n_fail++;
        $display("FAIL w1_rnd_ready: got 0 expected 1");
      end
      if1.a = a1; if1.b = b1;
      @(negedge clk);
      n = 0;
      while (!if1.out_valid && n < 20) begin @(negedge clk); n++; end
      chk("w1_rnd_lat", 64'(n), 64'd1);
      chk("w1_rnd_diff", 64'(if1.diff), 64'(a1 ^ b1));
      chk("w1_rnd_bout", 64'(if1.bout), 64'(!a1 && b1));
    end
    if1.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
